// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one OBI-style data memory port between the scalar core LSU
// (requester 0) and the vector LSU (requester 1). An address-phase request
// that the memory stalls stays locked to its requester until it is granted.
// An ID FIFO remembers which requester owns each outstanding transaction,
// so every data_rvalid_i response is routed back to the right requester.
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on ties.
// Without it, the core always wins a tie (fixed priority).
module dmem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int AW              = 32,
   parameter int DW              = 32
) (
   input  logic            clk,
   input  logic            reset,
   // scalar core LSU
   input  logic            core_req_i,
   input  logic            core_we_i,
   input  logic [DW/8-1:0] core_be_i,
   input  logic [AW-1:0]   core_addr_i,
   input  logic [DW-1:0]   core_wdata_i,
   output logic            core_gnt_o,
   output logic            core_rvalid_o,
   output logic [DW-1:0]   core_rdata_o,
   // vector LSU
   input  logic            vlsu_req_i,
   input  logic            vlsu_we_i,
   input  logic [DW/8-1:0] vlsu_be_i,
   input  logic [AW-1:0]   vlsu_addr_i,
   input  logic [DW-1:0]   vlsu_wdata_i,
   output logic            vlsu_gnt_o,
   output logic            vlsu_rvalid_o,
   output logic [DW-1:0]   vlsu_rdata_o,
   // shared memory port
   output logic            data_req_o,
   input  logic            data_gnt_i,
   input  logic            data_rvalid_i,
   output logic            data_we_o,
   output logic [DW/8-1:0] data_be_o,
   output logic [AW-1:0]   data_addr_o,
   output logic [DW-1:0]   data_wdata_o,
   input  logic [DW-1:0]   data_rdata_i,
   // status
   output logic [3:0]      outstanding_o,
   output logic            idle_o,
   output logic            err_o
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic {ID_CORE = 1'b0, ID_VLSU = 1'b1} req_id_e;
   typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_e;

   state_e        state_q;
   req_id_e       sel_q;
   req_id_e       sel;
   logic          sel_valid;
   logic          sel_req;
   logic          handshake;

   req_id_e       ids_q [MAX_OUTSTANDING];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [3:0]    count_q;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   req_id_e       head_id;

`ifdef DMEM_ARB_RR_EN
   // Requester that wins the next tie: the one not granted most recently.
   req_id_e       prio_q;
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
      return p + 1'b1;
   endfunction

   assign fifo_full  = (count_q == 4'(MAX_OUTSTANDING));
   assign fifo_empty = (count_q == 4'd0);
   assign head_id    = ids_q[rd_ptr_q];
   assign pop        = data_rvalid_i & ~fifo_empty;

   // Pick the requester that owns the address phase this cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      sel       = ID_CORE;
      sel_valid = 1'b0;
      if (state_q == ST_LOCKED) begin
         sel       = sel_q;
         sel_valid = 1'b1;
      end else if (core_req_i && vlsu_req_i) begin
         sel_valid = 1'b1;
`ifdef DMEM_ARB_RR_EN
         sel       = prio_q;
`else
         sel       = ID_CORE;
`endif
      end else if (core_req_i) begin
         sel_valid = 1'b1;
         sel       = ID_CORE;
      end else if (vlsu_req_i) begin
         sel_valid = 1'b1;
         sel       = ID_VLSU;
      end
   end

   assign sel_req    = (sel == ID_VLSU) ? vlsu_req_i : core_req_i;
   assign data_req_o = sel_valid & sel_req & ~fifo_full;
   assign handshake  = data_req_o & data_gnt_i;
   assign core_gnt_o = handshake & (sel == ID_CORE);
   assign vlsu_gnt_o = handshake & (sel == ID_VLSU);

   // Mux the request fields of the selected requester onto the memory port.
   always_comb begin
      data_we_o    = 1'b0;
      data_be_o    = '0;
      data_addr_o  = '0;
      data_wdata_o = '0;
      if (sel_valid) begin
         if (sel == ID_VLSU) begin
            data_we_o    = vlsu_we_i;
            data_be_o    = vlsu_be_i;
            data_addr_o  = vlsu_addr_i;
            data_wdata_o = vlsu_wdata_i;
         end else begin
            data_we_o    = core_we_i;
            data_be_o    = core_be_i;
            data_addr_o  = core_addr_i;
            data_wdata_o = core_wdata_i;
         end
      end
   end

   assign core_rvalid_o = pop & (head_id == ID_CORE);
   assign vlsu_rvalid_o = pop & (head_id == ID_VLSU);
   assign core_rdata_o  = data_rdata_i;
   assign vlsu_rdata_o  = data_rdata_i;

   assign outstanding_o = count_q;
   assign idle_o        = ~core_req_i & ~vlsu_req_i & fifo_empty;

   // ARB/LOCKED machine: hold a stalled request's owner until the memory grants it.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q <= ST_ARB;
         sel_q   <= ID_CORE;
      end else begin
         case (state_q)
            ST_ARB: begin
               if (data_req_o && !data_gnt_i) begin
                  state_q <= ST_LOCKED;
                  sel_q   <= sel;
               end
            end
            ST_LOCKED: begin
               if (handshake) state_q <= ST_ARB;
            end
            default: state_q <= ST_ARB;
         endcase
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Round-robin pointer: after a grant the other requester wins the next tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= ID_CORE;
      end else if (handshake) begin
         prio_q <= (sel == ID_CORE) ? ID_VLSU : ID_CORE;
      end
   end
`endif

   // ID FIFO pointers and occupancy; push on handshake, pop on a matched response.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 4'd0;
      end else begin
         if (handshake) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)       rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (handshake && !pop)      count_q <= count_q + 4'd1;
         else if (pop && !handshake) count_q <= count_q - 4'd1;
      end
   end

   // ID FIFO storage.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; entries are only read while the pointers mark them valid.
      if (handshake) ids_q[wr_ptr_q] <= sel;
   end

   // Sticky error flag for a response with no matching outstanding transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_o <= 1'b0;
      end else if (data_rvalid_i && fifo_empty) begin
         err_o <= 1'b1;
      end
   end

endmodule
